register_nbit_universal: RTL and testbench
==========================================

// Module: register_nbit_universal
// PURPOSE
//  Parametrised universal register, the successor to the fixed 8-bit enable register.
//  - Modes: hold, parallel load, shift, rotate, increment and decrement, each with a carry flag.
//  - Adds a snapshot register for sampling the live value without stopping it.
//  - Sits behind io_in/io_out pin mapping in the user project wrapper.
// PARAMETERS
//  WIDTH      8   data width in bits, >= 2
//  RESET_VAL  0   value loaded into q on reset, WIDTH bits
//  STEP       1   INC/DEC step, 1 .. 2**WIDTH-1
// PORTS
//  clk        in   1      single clock, rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  enable     in   1      operation qualifier; 0 = hold everything except snapshot
//  mode       in   3      operation select (see BEHAVIOUR)
//  d          in   WIDTH  parallel load data
//  ser_in     in   1      serial fill bit for SHL/SHR
//  cap        in   1      snapshot capture strobe
//  q          out  WIDTH  register value
//  carry      out  1      bit out / wrap flag of the last enabled op
//  zero       out  1      combinational, q == 0
//  q_snap     out  WIDTH  snapshot of q
//  snap_valid out  1      q_snap holds a captured value
//  parity     out  1      even parity of q (optional, see CONFIGURATION)
// BEHAVIOUR
//  Reset (async assert, sync deassert by the caller):
//   q=RESET_VAL, carry=0, q_snap=0, snap_valid=0.
//  All state updates on posedge clk; 1-cycle latency from inputs to q/carry.
//  enable=0: q and carry hold; mode, d and ser_in are ignored.
//  enable=1, by mode:
//   000 HOLD : q holds, carry<=0
//   001 LOAD : q<=d, carry<=0
//   010 SHL  : q<={q[W-2:0],ser_in}, carry<=q[W-1]
//   011 SHR  : q<={ser_in,q[W-1:1]}, carry<=q[0]
//   100 ROTL : q<={q[W-2:0],q[W-1]}, carry<=q[W-1]
//   101 ROTR : q<={q[0],q[W-1:1]}, carry<=q[0]
//   110 INC  : {carry,q}<=q+STEP, computed at W+1 bits; q wraps modulo 2**W, carry=1 on overflow
//   111 DEC  : q<=q-STEP modulo 2**W; carry=1 on borrow (q<STEP before the op)
//  Boundaries:
//   - INC from all-ones with STEP=1 gives q=0, carry=1.
//   - DEC from 0 gives q=all-ones, carry=1.
//   - carry is sticky only while enable=0; the next enabled op overwrites it.
//  Snapshot (independent of enable and mode):
//   - cap=1 at an edge: q_snap<=q as it was before that edge's update; snap_valid<=1.
//   - cap together with LOAD captures the old q, not d.
//   - snap_valid clears only on reset.
//  zero and parity are combinational from q. No other combinational paths from inputs to outputs.
//  Reset mid-operation: all outputs return to reset values at once; no pending state survives.
// CONFIGURATION
//  REG_UNIVERSAL_PARITY_EN defined:
//   - parity = ^q, i.e. 1 when q has an odd number of ones.
//  Undefined:
//   - parity is tied to 0 and the XOR tree is not synthesised.
//   - The port remains, so the pinout is stable.
// TESTING  (WIDTH=8, STEP=1, RESET_VAL=0 unless noted)
//  1. Drop reset_n mid-cycle while q=0x5A -> q=0x00, carry=0, snap_valid=0 immediately,
//     without waiting for a clock edge.
//  2. LOAD d=0x81, then SHL with ser_in=1 -> q=0x03, carry=1; then SHR with ser_in=0 -> q=0x01, carry=1.
//  3. LOAD 0xFF, then INC -> q=0x00, carry=1, zero=1; then DEC -> q=0xFF, carry=1.
//  4. LOAD 0x96, then 8x ROTL -> q=0x96 again, with carry sequence 1,0,0,1,0,1,1,0.
//  5. enable=0 with mode=LOAD, d=0x33 -> q unchanged; cap=1 with LOAD 0x44 and q=0x12
//     -> q=0x44, q_snap=0x12.
//  6. With REG_UNIVERSAL_PARITY_EN defined, q=0x07 -> parity=1.
//     Without it -> parity=0 for every q value.

Source files
------------

// File: rtl/register_nbit_universal.sv
// Parametrised universal register: hold/load/shift/rotate/inc/dec with carry, plus a snapshot.
// Define REG_UNIVERSAL_PARITY_EN to drive parity = ^q; otherwise parity is tied low.
module register_nbit_universal #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter logic [WIDTH-1:0]     STEP      = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  input  logic             cap,
  output logic [WIDTH-1:0] q,
  output logic             carry,
  output logic             zero,
  output logic [WIDTH-1:0] q_snap,
  output logic             snap_valid,
  output logic             parity
);

  typedef enum logic [2:0] {
    ModeHold = 3'b000,
    ModeLoad = 3'b001,
    ModeShl  = 3'b010,
    ModeShr  = 3'b011,
    ModeRotl = 3'b100,
    ModeRotr = 3'b101,
    ModeInc  = 3'b110,
    ModeDec  = 3'b111
  } mode_e;

  mode_e            op;
  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] snap_q;
  logic             snap_valid_q;
  logic [WIDTH:0]   sum, diff;

  assign op = mode_e'(mode);

  // Extra MSB of the W+1-bit result is the overflow (INC) or borrow (DEC).
  assign sum  = {1'b0, q_q} + {1'b0, STEP};
  assign diff = {1'b0, q_q} - {1'b0, STEP};

  always_comb begin
    q_d     = q_q;
    carry_d = carry_q;
    if (enable) begin
      unique case (op)
        ModeHold: begin
          q_d     = q_q;
          carry_d = 1'b0;
        end
        ModeLoad: begin
          q_d     = d;
          carry_d = 1'b0;
        end
        ModeShl: begin
          q_d     = {q_q[WIDTH-2:0], ser_in};
          carry_d = q_q[WIDTH-1];
        end
        ModeShr: begin
          q_d     = {ser_in, q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        ModeRotl: begin
          q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          carry_d = q_q[WIDTH-1];
        end
        ModeRotr: begin
          q_d     = {q_q[0], q_q[WIDTH-1:1]};
          carry_d = q_q[0];
        end
        ModeInc: begin
          q_d     = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
        end
        ModeDec: begin
          q_d     = diff[WIDTH-1:0];
          carry_d = diff[WIDTH];
        end
        default: begin
          q_d     = q_q;
          carry_d = carry_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q     <= RESET_VAL;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
    end
  end

  // Snapshot samples the pre-update q and ignores enable/mode entirely.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else if (cap) begin
      snap_q       <= q_q;
      snap_valid_q <= 1'b1;
    end
  end

  assign q          = q_q;
  assign carry      = carry_q;
  assign zero       = (q_q == '0);
  assign q_snap     = snap_q;
  assign snap_valid = snap_valid_q;

`ifdef REG_UNIVERSAL_PARITY_EN
  assign parity = ^q_q;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_register_nbit_universal.sv
// Directed self-checking bench for register_nbit_universal (WIDTH=8, STEP=1, RESET_VAL=0).
module tb_register_nbit_universal;

  localparam logic [2:0] MHold = 3'b000, MLoad = 3'b001, MShl = 3'b010, MShr = 3'b011;
  localparam logic [2:0] MRotl = 3'b100, MRotr = 3'b101, MInc = 3'b110, MDec = 3'b111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [2:0] mode;
  logic [7:0] d;
  logic       ser_in;
  logic       cap;
  logic [7:0] q;
  logic       carry;
  logic       zero;
  logic [7:0] q_snap;
  logic       snap_valid;
  logic       parity;

  int errors = 0;
  int checks = 0;

  register_nbit_universal #(
    .WIDTH    (8),
    .RESET_VAL(8'h00),
    .STEP     (8'h01)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .mode      (mode),
    .d         (d),
    .ser_in    (ser_in),
    .cap       (cap),
    .q         (q),
    .carry     (carry),
    .zero      (zero),
    .q_snap    (q_snap),
    .snap_valid(snap_valid),
    .parity    (parity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Checks q, carry, zero and parity against a hand-computed q/carry.
  task automatic check_q(input string tag, input logic [7:0] exp_q, input logic exp_c);
    logic exp_p;
`ifdef REG_UNIVERSAL_PARITY_EN
    exp_p = ^exp_q;
`else
    exp_p = 1'b0;
`endif
    check({tag, ".q"}, 32'(q), 32'(exp_q));
    check({tag, ".carry"}, 32'(carry), 32'(exp_c));
    check({tag, ".zero"}, 32'(zero), 32'(exp_q == 8'h00));
    check({tag, ".parity"}, 32'(parity), 32'(exp_p));
  endtask

  // Drive one cycle's inputs on the falling edge; sample 1 time unit after the rising edge.
  task automatic step(input logic en, input logic [2:0] m, input logic [7:0] dd,
                      input logic si, input logic c);
    @(negedge clk);
    enable = en;
    mode   = m;
    d      = dd;
    ser_in = si;
    cap    = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rot_q [8];
    logic       rot_c [8];
    rot_q = '{8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4B, 8'h96};
    rot_c = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset_n = 1'b0;
    enable  = 1'b0;
    mode    = MHold;
    d       = 8'h00;
    ser_in  = 1'b0;
    cap     = 1'b0;
    #2;
    check_q("reset", 8'h00, 1'b0);
    check("reset.q_snap", 32'(q_snap), 32'h0);
    check("reset.snap_valid", 32'(snap_valid), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Build q=0x5A with carry=1 and a valid snapshot, then reset between edges.
    step(1'b1, MLoad, 8'hAD, 1'b0, 1'b0);
    check_q("load_ad", 8'hAD, 1'b0);
    step(1'b1, MShl, 8'h00, 1'b0, 1'b1);
    check_q("shl_5a", 8'h5A, 1'b1);
    check("shl_5a.q_snap", 32'(q_snap), 32'hAD);
    check("shl_5a.snap_valid", 32'(snap_valid), 32'h1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_q("async_rst", 8'h00, 1'b0);
    check("async_rst.q_snap", 32'(q_snap), 32'h0);
    check("async_rst.snap_valid", 32'(snap_valid), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Shifts with serial fill.
    step(1'b1, MLoad, 8'h81, 1'b0, 1'b0);
    check_q("load_81", 8'h81, 1'b0);
    step(1'b1, MShl, 8'h00, 1'b1, 1'b0);
    check_q("shl_03", 8'h03, 1'b1);
    step(1'b1, MShr, 8'h00, 1'b0, 1'b0);
    check_q("shr_01", 8'h01, 1'b1);

    // INC/DEC wrap boundaries and a plain DEC without borrow.
    step(1'b1, MLoad, 8'hFF, 1'b0, 1'b0);
    check_q("load_ff", 8'hFF, 1'b0);
    step(1'b1, MInc, 8'h00, 1'b0, 1'b0);
    check_q("inc_wrap", 8'h00, 1'b1);
    step(1'b1, MDec, 8'h00, 1'b0, 1'b0);
    check_q("dec_wrap", 8'hFF, 1'b1);
    step(1'b1, MDec, 8'h00, 1'b0, 1'b0);
    check_q("dec_fe", 8'hFE, 1'b0);
    step(1'b1, MInc, 8'h00, 1'b0, 1'b0);
    check_q("inc_ff", 8'hFF, 1'b0);

    // Full rotate-left cycle.
    step(1'b1, MLoad, 8'h96, 1'b0, 1'b0);
    check_q("load_96", 8'h96, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, MRotl, 8'h00, 1'b1, 1'b0);
      check_q($sformatf("rotl%0d", i), rot_q[i], rot_c[i]);
    end
    step(1'b1, MRotr, 8'h00, 1'b1, 1'b0);
    check_q("rotr_4b", 8'h4B, 1'b0);
    step(1'b1, MRotr, 8'h00, 1'b0, 1'b0);
    check_q("rotr_a5", 8'hA5, 1'b1);

    // Disabled: q and carry hold, inputs ignored; then HOLD clears carry.
    step(1'b0, MLoad, 8'h33, 1'b1, 1'b0);
    check_q("dis_hold", 8'hA5, 1'b1);
    step(1'b1, MHold, 8'h33, 1'b1, 1'b0);
    check_q("hold_clr", 8'hA5, 1'b0);

    // Snapshot with LOAD takes the old q; capture also works while disabled.
    step(1'b1, MLoad, 8'h12, 1'b0, 1'b0);
    check_q("load_12", 8'h12, 1'b0);
    step(1'b1, MLoad, 8'h44, 1'b0, 1'b1);
    check_q("cap_load", 8'h44, 1'b0);
    check("cap_load.q_snap", 32'(q_snap), 32'h12);
    check("cap_load.snap_valid", 32'(snap_valid), 32'h1);
    step(1'b0, MInc, 8'h00, 1'b0, 1'b1);
    check_q("cap_dis", 8'h44, 1'b0);
    check("cap_dis.q_snap", 32'(q_snap), 32'h44);
    step(1'b1, MLoad, 8'h07, 1'b0, 1'b0);
    check_q("load_07", 8'h07, 1'b0);
    check("hold_snap.q_snap", 32'(q_snap), 32'h44);
    check("hold_snap.snap_valid", 32'(snap_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
